// File: rtl/logic_operand_fetch_if.sv
// Issue, writeback and operand-bundle signals of the logic-unit operand fetch stage.
// The master drives issue/writeback/out_ready; the slave (fetch stage) drives the rest.
interface logic_operand_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_sel;
  logic [2:0]  in_rs1;
  logic [2:0]  in_rs2;
  logic [2:0]  in_rd;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [63:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [2:0]  out_sel;
  logic [2:0]  out_rd;
  logic [15:0] stall_cnt;

  modport master (
    output in_valid, in_sel, in_rs1, in_rs2, in_rd,
    output wb_en, wb_addr, wb_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_sel, out_rd, stall_cnt
  );

  modport slave (
    input  in_valid, in_sel, in_rs1, in_rs2, in_rd,
    input  wb_en, wb_addr, wb_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_sel, out_rd, stall_cnt
  );
endinterface

// File: rtl/logic_operand_fetch.sv
// Operand fetch for the logic unit: 8x64 regfile, busy scoreboard, writeback bypass.
// Latency 1 cycle; a held bundle (out_ready=0) blocks new accepts, hazards drop in_ready.
module logic_operand_fetch (
  input logic                 clk,
  input logic                 rst_n,
  logic_operand_fetch_if.slave bus
);

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  sel;
    logic [2:0]  rd;
  } bundle_t;

  logic [63:0] rf [8];
  logic [7:0]  busy;
  logic [7:0]  eff_busy;
  logic [7:0]  busy_nxt;
  logic        out_valid_q;
  bundle_t     out_q;
  bundle_t     bundle_d;
  logic [15:0] stall_q;
  logic        slot_free;
  logic        hazard;
  logic        accept;

  // A writeback landing this cycle already frees its index for issue.
  always_comb begin
    eff_busy = busy;
    if (bus.wb_en) eff_busy[bus.wb_addr] = 1'b0;
  end

  assign slot_free    = !out_valid_q || bus.out_ready;
  assign hazard       = eff_busy[bus.in_rs1] || eff_busy[bus.in_rs2] || eff_busy[bus.in_rd];
  assign bus.in_ready = slot_free && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    bundle_d.a   = (bus.wb_en && bus.wb_addr == bus.in_rs1) ? bus.wb_data : rf[bus.in_rs1];
    bundle_d.b   = (bus.wb_en && bus.wb_addr == bus.in_rs2) ? bus.wb_data : rf[bus.in_rs2];
    bundle_d.sel = bus.in_sel;
    bundle_d.rd  = bus.in_rd;
  end

  // Set after clear so a same-cycle issue to the retiring index keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (bus.wb_en) busy_nxt[bus.wb_addr] = 1'b0;
    if (accept)    busy_nxt[bus.in_rd]   = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (bus.wb_en) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      stall_q     <= '0;
    end else begin
      busy <= busy_nxt;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_q       <= bundle_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (bus.in_valid && slot_free && hazard && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_q.a;
  assign bus.out_b     = out_q.b;
  assign bus.out_sel   = out_q.sel;
  assign bus.out_rd    = out_q.rd;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_logic_operand_fetch.sv
// Directed bench for logic_operand_fetch: regfile read, hazards, bypass, backpressure, saturation, reset.
module tb_logic_operand_fetch;

  logic clk;
  logic rst_n;
  int   vec;
  int   errs;

  logic_operand_fetch_if bus ();

  logic_operand_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic v, input logic [2:0] sel, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [2:0] rd);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
  endtask

  task automatic wb(input logic en, input logic [2:0] addr, input logic [63:0] data);
    bus.wb_en   = en;
    bus.wb_addr = addr;
    bus.wb_data = data;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    issue(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    wb(1'b0, 3'd0, 64'd0);
    bus.out_ready = 1'b1;
    #3;
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    vec++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    vec++; if (bus.out_a !== 64'd0 || bus.out_b !== 64'd0) begin errs++; $display("FAIL reset_out_ab: got %h %h want 0 0", bus.out_a, bus.out_b); end
    vec++; if (bus.stall_cnt !== 16'd0) begin errs++; $display("FAIL reset_stall: got %0d want 0", bus.stall_cnt); end
    issue(1'b0, 3'd7, 3'd7, 3'd7, 3'd7);
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    wb(1'b1, 3'd1, 64'h0000_0000_FFC0_0070);
    tick();
    wb(1'b1, 3'd2, 64'h7186_9861_DEDE_73BB);
    tick();
    wb(1'b0, 3'd0, 64'd0);
    issue(1'b1, 3'd3, 3'd1, 3'd2, 3'd3);
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL basic_in_ready: got %0b want 1", bus.in_ready); end
    tick();
    issue(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    vec++; if (bus.out_valid !== 1'b1) begin errs++; $display("FAIL basic_out_valid: got %0b want 1", bus.out_valid); end
    vec++; if (bus.out_a !== 64'h0000_0000_FFC0_0070) begin errs++; $display("FAIL basic_out_a: got %h want 00000000ffc00070", bus.out_a); end
    vec++; if (bus.out_b !== 64'h7186_9861_DEDE_73BB) begin errs++; $display("FAIL basic_out_b: got %h want 71869861dede73bb", bus.out_b); end
    vec++; if (bus.out_sel !== 3'd3 || bus.out_rd !== 3'd3) begin errs++; $display("FAIL basic_sel_rd: got %0d %0d want 3 3", bus.out_sel, bus.out_rd); end
    tick();
    vec++; if (bus.out_valid !== 1'b0) begin errs++; $display("FAIL basic_drain: got %0b want 0", bus.out_valid); end
    vec++; if (bus.out_sel !== 3'd3) begin errs++; $display("FAIL basic_hold_sel: got %0d want 3", bus.out_sel); end
  endtask

  task automatic test_raw_hazard();
    issue(1'b1, 3'd5, 3'd3, 3'd0, 3'd4);
    #1;
    vec++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL raw_blocked: got %0b want 0", bus.in_ready); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      vec++; if (bus.stall_cnt !== 16'(i)) begin errs++; $display("FAIL raw_stall_cnt: got %0d want %0d", bus.stall_cnt, i); end
    end
    wb(1'b1, 3'd3, 64'hDEAD_BEEF_0000_0001);
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL raw_release: got %0b want 1", bus.in_ready); end
    tick();
    issue(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    wb(1'b1, 3'd4, 64'd4);
    vec++; if (bus.out_a !== 64'hDEAD_BEEF_0000_0001) begin errs++; $display("FAIL raw_bypass_a: got %h want deadbeef00000001", bus.out_a); end
    vec++; if (bus.out_b !== 64'd0 || bus.out_rd !== 3'd4) begin errs++; $display("FAIL raw_b_rd: got %h %0d want 0 4", bus.out_b, bus.out_rd); end
    vec++; if (bus.stall_cnt !== 16'd3) begin errs++; $display("FAIL raw_stall_final: got %0d want 3", bus.stall_cnt); end
    tick();
    wb(1'b0, 3'd0, 64'd0);
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    issue(1'b1, 3'd1, 3'd1, 3'd2, 3'd5);
    tick();
    issue(1'b1, 3'd2, 3'd2, 3'd1, 3'd6);
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready: got %0b want 0", bus.in_ready); end
      tick();
      vec++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'h0000_0000_FFC0_0070 || bus.out_sel !== 3'd1 || bus.out_rd !== 3'd5)
        begin errs++; $display("FAIL bp_hold: got v=%0b a=%h sel=%0d rd=%0d want 1 ffc00070 1 5", bus.out_valid, bus.out_a, bus.out_sel, bus.out_rd); end
      vec++; if (bus.stall_cnt !== 16'd3) begin errs++; $display("FAIL bp_stall_cnt: got %0d want 3", bus.stall_cnt); end
    end
    bus.out_ready = 1'b1;
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL bp_resume_ready: got %0b want 1", bus.in_ready); end
    tick();
    issue(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    vec++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'h7186_9861_DEDE_73BB || bus.out_sel !== 3'd2)
      begin errs++; $display("FAIL bp_back_to_back: got v=%0b a=%h sel=%0d want 1 71869861dede73bb 2", bus.out_valid, bus.out_a, bus.out_sel); end
    tick();
  endtask

  task automatic test_wb_set_wins();
    wb(1'b1, 3'd5, 64'h55);
    issue(1'b1, 3'd0, 3'd0, 3'd0, 3'd5);
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL sw_accept: got %0b want 1", bus.in_ready); end
    tick();
    wb(1'b0, 3'd0, 64'd0);
    issue(1'b1, 3'd4, 3'd5, 3'd5, 3'd7);
    #1;
    vec++; if (bus.in_ready !== 1'b0) begin errs++; $display("FAIL sw_busy_kept: got %0b want 0", bus.in_ready); end
    repeat (2) tick();
    vec++; if (bus.stall_cnt !== 16'd5) begin errs++; $display("FAIL sw_stall_cnt: got %0d want 5", bus.stall_cnt); end
    wb(1'b1, 3'd5, 64'h5555_0000_AAAA_0005);
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL sw_release: got %0b want 1", bus.in_ready); end
    tick();
    wb(1'b0, 3'd0, 64'd0);
    issue(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    vec++; if (bus.out_a !== 64'h5555_0000_AAAA_0005 || bus.out_b !== 64'h5555_0000_AAAA_0005)
      begin errs++; $display("FAIL sw_same_src: got %h %h want 55550000aaaa0005 x2", bus.out_a, bus.out_b); end
    tick();
  endtask

  task automatic test_nonbusy_wb();
    wb(1'b1, 3'd0, 64'h0123_4567_89AB_CDEF);
    tick();
    wb(1'b0, 3'd0, 64'd0);
    issue(1'b1, 3'd6, 3'd0, 3'd4, 3'd0);
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL nb_ready: got %0b want 1", bus.in_ready); end
    tick();
    issue(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    vec++; if (bus.out_a !== 64'h0123_4567_89AB_CDEF || bus.out_b !== 64'd4)
      begin errs++; $display("FAIL nb_operands: got %h %h want 0123456789abcdef 4", bus.out_a, bus.out_b); end
    tick();
  endtask

  task automatic test_stall_saturate_and_reset();
    issue(1'b1, 3'd0, 3'd1, 3'd1, 3'd2);
    tick();
    issue(1'b1, 3'd0, 3'd2, 3'd1, 3'd3);
    repeat (65540) tick();
    vec++; if (bus.stall_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_reach: got %h want ffff", bus.stall_cnt); end
    repeat (2) tick();
    vec++; if (bus.stall_cnt !== 16'hFFFF) begin errs++; $display("FAIL sat_hold: got %h want ffff", bus.stall_cnt); end
    bus.out_ready = 1'b0;
    wb(1'b1, 3'd2, 64'hA);
    tick();
    wb(1'b0, 3'd0, 64'd0);
    issue(1'b0, 3'd0, 3'd3, 3'd3, 3'd3);
    vec++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'hA) begin errs++; $display("FAIL mid_bundle: got v=%0b a=%h want 1 a", bus.out_valid, bus.out_a); end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    vec++; if (bus.out_valid !== 1'b0 || bus.out_a !== 64'd0) begin errs++; $display("FAIL async_rst_out: got v=%0b a=%h want 0 0", bus.out_valid, bus.out_a); end
    vec++; if (bus.stall_cnt !== 16'd0) begin errs++; $display("FAIL async_rst_stall: got %h want 0", bus.stall_cnt); end
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL async_rst_busy: got %0b want 1", bus.in_ready); end
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    issue(1'b1, 3'd1, 3'd2, 3'd0, 3'd3);
    #1;
    vec++; if (bus.in_ready !== 1'b1) begin errs++; $display("FAIL post_rst_ready: got %0b want 1", bus.in_ready); end
    tick();
    issue(1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    vec++; if (bus.out_valid !== 1'b1 || bus.out_a !== 64'd0 || bus.out_b !== 64'd0)
      begin errs++; $display("FAIL post_rst_rf: got v=%0b a=%h b=%h want 1 0 0", bus.out_valid, bus.out_a, bus.out_b); end
    tick();
  endtask

  initial begin
    vec  = 0;
    errs = 0;
    test_reset();
    test_basic();
    test_raw_hazard();
    test_backpressure();
    test_wb_set_wins();
    test_nonbusy_wb();
    test_stall_saturate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/logic_operand_fetch.md
LOGIC_OPERAND_FETCH -- requirements
Module: logic_operand_fetch

Interface
REQ-001 The block SHALL have no parameters; register file depth 8, data width 64, select width 3 are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  issue slot carries an instruction.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 in_sel  input  3  logic-unit operation select, passed through unchanged.
REQ-007 in_rs1, in_rs2  input  3 each  source register indices for operands A, B.
REQ-008 in_rd  input  3  destination register index.
REQ-009 wb_en  input  1  writeback strobe from logic-unit result path.
REQ-010 wb_addr  input  3  writeback register index.
REQ-011 wb_data  input  64  writeback value.
REQ-012 out_valid  output  1  operand bundle valid toward logic unit.
REQ-013 out_ready  input  1  logic-unit side consumes bundle.
REQ-014 out_a, out_b  output  64 each  operands A and B for the logic unit.
REQ-015 out_sel  output  3  registered copy of in_sel.
REQ-016 out_rd  output  3  registered copy of in_rd.
REQ-017 stall_cnt  output  16  saturating count of hazard-stalled cycles.

Function
REQ-018 Register file: 8 x 64-bit entries; write when wb_en=1 at the clock edge, wb_data to entry wb_addr; all entries writable (no hard-wired zero).
REQ-019 Scoreboard: 8 busy bits; busy[x] marks an accepted, not-yet-written-back destination.
REQ-020 eff_busy[x] = busy[x] AND NOT (wb_en AND wb_addr==x), evaluated combinationally each cycle.
REQ-021 slot_free = NOT out_valid OR out_ready.
REQ-022 hazard = eff_busy[in_rs1] OR eff_busy[in_rs2] OR eff_busy[in_rd].
REQ-023 in_ready = slot_free AND NOT hazard; combinational, dependent on in_rs1/in_rs2/in_rd; in_ready need not be gated by in_valid.
REQ-024 Accept = in_valid AND in_ready; on accept, output register loads out_a, out_b, out_sel=in_sel, out_rd=in_rd, and out_valid=1 at the next edge; latency one cycle.
REQ-025 Operand read with bypass: if wb_en AND wb_addr==in_rsN, operand N = wb_data, else regfile[in_rsN]; in_rs1==in_rs2 yields identical A and B.
REQ-026 On accept, busy[in_rd] set at the edge; if the same edge clears the same index via writeback, set wins.
REQ-027 On wb_en, busy[wb_addr] cleared at the edge unless REQ-026 sets it.
REQ-028 Writeback to a non-busy index SHALL still update the regfile and leave busy unchanged.
REQ-029 If out_valid=1 AND out_ready=0, all out_* hold stable; no new accept.
REQ-030 If out_valid=1 AND out_ready=1 and no accept this cycle, out_valid=0 next cycle; out_a/out_b/out_sel/out_rd hold their last values.
REQ-031 Back-to-back: consume and accept in the same cycle gives out_valid=1 continuously, full throughput.
REQ-032 stall_cnt increments by 1 each cycle with in_valid=1 AND slot_free=1 AND hazard=1; holds at 16'hFFFF.
REQ-033 Backpressure-only stalls (slot_free=0) SHALL NOT increment stall_cnt.

Reset
REQ-034 rst_n=0 asynchronously clears: all regfile entries to 0, all busy bits to 0, out_valid=0, out_a=0, out_b=0, out_sel=0, out_rd=0, stall_cnt=0.
REQ-035 Reset mid-operation discards any held bundle and all pending busy bits; first cycle after release has in_ready=1 for any indices.

Verification
REQ-036 Reset then wb r1=64'h0000_0000_FFC0_0070, wb r2=64'h7186_9861_DEDE_73BB; issue sel=3, rs1=1, rs2=2, rd=3, out_ready=1 -> next cycle out_valid=1, out_a/out_b match written values, out_sel=3, out_rd=3.
REQ-037 RAW hazard: issue rd=3, then issue rs1=3 -> in_ready=0, stall_cnt increments each cycle; wb r3=64'hDEAD_BEEF_0000_0001 -> same cycle in_ready=1, out_a=64'hDEAD_BEEF_0000_0001 next cycle via bypass.
REQ-038 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> out_* stable, in_ready=0, stall_cnt unchanged; out_ready=1 -> accept, continuous out_valid.
REQ-039 Simultaneous wb r5 and accept rd=5 -> busy[5]=1 after edge; following issue rs1=5 stalls until next wb r5.
REQ-040 Force 65,540 hazard cycles -> stall_cnt=16'hFFFF, holds; assert rst_n=0 mid-bundle -> out_valid=0, stall_cnt=0, busy cleared immediately.
